// File: rtl/multi_counter_acc.sv
`default_nettype none
// ============================================================================
// Module   : multi_counter_acc
// Brief    : RAM-backed counter bank with a 4-stage command pipeline and
//            same-ID forwarding. Define MULTI_COUNTER_ACC_SAT_EN to saturate
//            on overflow/underflow instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module multi_counter_acc #(
    parameter int CNTRS_N    = 256,
    parameter int CNTRS_W    = 32,
    parameter int CNTRS_ID_W = $clog2(CNTRS_N)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_vld,
    output logic                  cmd_rdy,
    input  logic [CNTRS_ID_W-1:0] cmd_id,
    input  logic [2:0]            cmd_op,
    input  logic [CNTRS_W-1:0]    cmd_dat,
    input  logic                  clr_all,
    output logic                  status_vld_r,
    output logic                  status_qry_r,
    output logic [CNTRS_ID_W-1:0] status_id_r,
    output logic [CNTRS_W-1:0]    status_dat_r,
    output logic                  status_ovf_r
);

    localparam logic [2:0] c_OP_INIT = 3'd1;
    localparam logic [2:0] c_OP_INCR = 3'd2;
    localparam logic [2:0] c_OP_DECR = 3'd3;
    localparam logic [2:0] c_OP_ADD  = 3'd4;
    localparam logic [2:0] c_OP_SUB  = 3'd5;
    localparam logic [2:0] c_OP_QRY  = 3'd6;

    localparam logic [1:0] c_ST_SWEEP = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;

    localparam logic [CNTRS_ID_W-1:0] c_LAST_ADDR = CNTRS_ID_W'(CNTRS_N - 1);
    localparam logic [CNTRS_ID_W-1:0] c_ID_ONE    = CNTRS_ID_W'(1);
    localparam logic [CNTRS_W:0]      c_ONE       = (CNTRS_W + 1)'(1);

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [CNTRS_ID_W-1:0] r_sweep_addr;
    logic                  r_cmd_rdy;
    logic                  w_acc;
    logic                  w_cmd_live;

    logic                  r_s1_vld;
    logic [2:0]            r_s1_op;
    logic [CNTRS_ID_W-1:0] r_s1_id;
    logic [CNTRS_W-1:0]    r_s1_dat;

    logic                  r_s2_vld;
    logic                  r_s2_qry;
    logic                  r_s2_ovf;
    logic [CNTRS_ID_W-1:0] r_s2_id;
    logic [CNTRS_W-1:0]    r_s2_dat;

    logic                  r_s3_vld;
    logic                  r_s3_qry;
    logic                  r_s3_ovf;
    logic [CNTRS_ID_W-1:0] r_s3_id;
    logic [CNTRS_W-1:0]    r_s3_dat;

    logic [CNTRS_W-1:0]    r_mem [CNTRS_N];
    logic [CNTRS_W-1:0]    r_ram_q;
    logic                  w_wr_en;
    logic [CNTRS_ID_W-1:0] w_wr_addr;
    logic [CNTRS_W-1:0]    w_wr_dat;

    logic [CNTRS_W-1:0]    w_old;
    logic [CNTRS_W:0]      w_old_x;
    logic [CNTRS_W:0]      w_opd_x;
    logic [CNTRS_W:0]      w_sum;
    logic                  w_ovf;
    logic [CNTRS_W-1:0]    w_res;

    assign cmd_rdy    = r_cmd_rdy;
    // A clr_all request wins over a command presented in the same cycle
    assign w_acc      = cmd_vld & r_cmd_rdy & ~clr_all;
    assign w_cmd_live = (cmd_op >= c_OP_INIT) && (cmd_op <= c_OP_QRY);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_SWEEP: if (r_sweep_addr == c_LAST_ADDR) w_state_nxt = c_ST_RUN;
            c_ST_RUN:   if (clr_all) w_state_nxt = c_ST_DRAIN;
            c_ST_DRAIN: if (!(r_s1_vld || r_s2_vld || r_s3_vld)) w_state_nxt = c_ST_SWEEP;
            default:    w_state_nxt = c_ST_SWEEP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_ST_SWEEP;
            r_sweep_addr <= '0;
            r_cmd_rdy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cmd_rdy <= (w_state_nxt == c_ST_RUN);
            if (r_state == c_ST_SWEEP)
                r_sweep_addr <= (r_sweep_addr == c_LAST_ADDR) ? '0 : r_sweep_addr + c_ID_ONE;
        end
    end

    // Stage 2 holds the only result not yet visible through the RAM read path
    always_comb begin
        w_old   = (r_s2_vld && (r_s2_id == r_s1_id)) ? r_s2_dat : r_ram_q;
        w_old_x = {1'b0, w_old};
        w_opd_x = {1'b0, r_s1_dat};
        w_sum   = w_old_x;
        case (r_s1_op)
            c_OP_INIT: w_sum = w_opd_x;
            c_OP_INCR: w_sum = w_old_x + c_ONE;
            c_OP_DECR: w_sum = w_old_x - c_ONE;
            c_OP_ADD:  w_sum = w_old_x + w_opd_x;
            c_OP_SUB:  w_sum = w_old_x - w_opd_x;
            default:   w_sum = w_old_x;
        endcase
        w_ovf = w_sum[CNTRS_W];
`ifdef MULTI_COUNTER_ACC_SAT_EN
        if (w_ovf)
            w_res = ((r_s1_op == c_OP_DECR) || (r_s1_op == c_OP_SUB)) ? '0 : '1;
        else
            w_res = w_sum[CNTRS_W-1:0];
`else
        w_res = w_sum[CNTRS_W-1:0];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld     <= 1'b0;
            r_s1_op      <= '0;
            r_s1_id      <= '0;
            r_s1_dat     <= '0;
            r_s2_vld     <= 1'b0;
            r_s2_qry     <= 1'b0;
            r_s2_ovf     <= 1'b0;
            r_s2_id      <= '0;
            r_s2_dat     <= '0;
            r_s3_vld     <= 1'b0;
            r_s3_qry     <= 1'b0;
            r_s3_ovf     <= 1'b0;
            r_s3_id      <= '0;
            r_s3_dat     <= '0;
            status_vld_r <= 1'b0;
            status_qry_r <= 1'b0;
            status_ovf_r <= 1'b0;
            status_id_r  <= '0;
            status_dat_r <= '0;
        end else begin
            r_s1_vld <= w_acc && w_cmd_live;
            if (w_acc) begin
                r_s1_op  <= cmd_op;
                r_s1_id  <= cmd_id;
                r_s1_dat <= cmd_dat;
            end
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_s2_qry <= (r_s1_op == c_OP_QRY);
                r_s2_ovf <= w_ovf;
                r_s2_id  <= r_s1_id;
                r_s2_dat <= w_res;
            end
            r_s3_vld <= r_s2_vld;
            if (r_s2_vld) begin
                r_s3_qry <= r_s2_qry;
                r_s3_ovf <= r_s2_ovf;
                r_s3_id  <= r_s2_id;
                r_s3_dat <= r_s2_dat;
            end
            status_vld_r <= r_s3_vld;
            if (r_s3_vld) begin
                status_qry_r <= r_s3_qry;
                status_ovf_r <= r_s3_ovf;
                status_id_r  <= r_s3_id;
                status_dat_r <= r_s3_dat;
            end
        end
    end

    always_comb begin
        if (r_state == c_ST_SWEEP) begin
            w_wr_en   = 1'b1;
            w_wr_addr = r_sweep_addr;
            w_wr_dat  = '0;
        end else begin
            w_wr_en   = r_s2_vld && !r_s2_qry;
            w_wr_addr = r_s2_id;
            w_wr_dat  = r_s2_dat;
        end
    end

    // Write-first read port: a same-address write is returned on the read
    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_mem[w_wr_addr] <= w_wr_dat;
        r_ram_q <= (w_wr_en && (w_wr_addr == cmd_id)) ? w_wr_dat : r_mem[cmd_id];
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_counter_acc.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_counter_acc
// Brief    : Self-checking bench for multi_counter_acc (16 x 8-bit counters)
//            against a sequential behavioural model of the counter bank.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_counter_acc;

    localparam int N = 16;
`ifdef MULTI_COUNTER_ACC_SAT_EN
    localparam bit c_SAT = 1'b1;
`else
    localparam bit c_SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_vld;
    logic       cmd_rdy;
    logic [3:0] cmd_id;
    logic [2:0] cmd_op;
    logic [7:0] cmd_dat;
    logic       clr_all;
    logic       status_vld_r;
    logic       status_qry_r;
    logic [3:0] status_id_r;
    logic [7:0] status_dat_r;
    logic       status_ovf_r;

    always #5 clk = ~clk;

    multi_counter_acc #(.CNTRS_N(16), .CNTRS_W(8), .CNTRS_ID_W(4)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_vld      (cmd_vld),
        .cmd_rdy      (cmd_rdy),
        .cmd_id       (cmd_id),
        .cmd_op       (cmd_op),
        .cmd_dat      (cmd_dat),
        .clr_all      (clr_all),
        .status_vld_r (status_vld_r),
        .status_qry_r (status_qry_r),
        .status_id_r  (status_id_r),
        .status_dat_r (status_dat_r),
        .status_ovf_r (status_ovf_r)
    );

    typedef struct { int due; bit qry; int id; int dat; bit ovf; } exp_t;
    typedef struct { bit qry; int id; int dat; bit ovf; } obs_t;

    exp_t exp_q[$];
    obs_t seen[$];
    int   model_cnt [N];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   clr_cyc = 0;
    int   clr_last_due = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Sequential reference: every accepted command applied in order, using plain integers
    function automatic void model_apply(input int op, input int id, input int dat);
        exp_t e;
        int   v;
        if (op < 1 || op > 6) return;
        v = model_cnt[id];
        case (op)
            1:       v = dat;
            2:       v = v + 1;
            3:       v = v - 1;
            4:       v = v + dat;
            5:       v = v - dat;
            default: v = v;
        endcase
        e.ovf = 1'b0;
        if (v > 255) begin
            e.ovf = 1'b1;
            v = c_SAT ? 255 : v - 256;
        end else if (v < 0) begin
            e.ovf = 1'b1;
            v = c_SAT ? 0 : v + 256;
        end
        model_cnt[id] = v;
        e.due = cyc + 4;
        e.qry = (op == 6);
        e.id  = id;
        e.dat = v;
        exp_q.push_back(e);
    endfunction

    always @(negedge clk) begin
        exp_t e_head;
        obs_t o;
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            foreach (model_cnt[i]) model_cnt[i] = 0;
            chk("rst_cmd_rdy", cmd_rdy, 0);
            chk("rst_status_vld", status_vld_r, 0);
            chk("rst_status_qry", status_qry_r, 0);
            chk("rst_status_id", status_id_r, 0);
            chk("rst_status_dat", status_dat_r, 0);
            chk("rst_status_ovf", status_ovf_r, 0);
        end else begin
            if (status_vld_r) begin
                o.qry = status_qry_r;
                o.id  = status_id_r;
                o.dat = status_dat_r;
                o.ovf = status_ovf_r;
                seen.push_back(o);
            end
            if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
                e_head = exp_q.pop_front();
                chk("status_vld", status_vld_r, 1);
                chk("status_qry", status_qry_r, e_head.qry);
                chk("status_id", status_id_r, e_head.id);
                chk("status_dat", status_dat_r, e_head.dat);
                chk("status_ovf", status_ovf_r, e_head.ovf);
            end else begin
                chk("status_vld_idle", status_vld_r, 0);
            end
            if (cmd_rdy && clr_all) begin
                clr_cyc      = cyc;
                clr_last_due = (exp_q.size() != 0) ? exp_q[$].due : cyc;
                foreach (model_cnt[i]) model_cnt[i] = 0;
            end else if (cmd_vld && cmd_rdy) begin
                model_apply(int'(cmd_op), int'(cmd_id), int'(cmd_dat));
            end
        end
    end

    task automatic drive(input bit vld, input int op, input int id, input int dat, input bit clr);
        cmd_vld = vld;
        cmd_op  = 3'(op);
        cmd_id  = 4'(id);
        cmd_dat = 8'(dat);
        clr_all = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 0, 0, 0, 1'b0);
    endtask

    task automatic sweep_check(input string name);
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            chk({name, "_sweep_rdy_low"}, cmd_rdy, 0);
        end
        @(negedge clk);
        chk({name, "_rdy_high"}, cmd_rdy, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_seen(input string name, input int idx, input int dat, input int ovf);
        chk({name, "_present"}, seen.size() > idx, 1);
        if (seen.size() > idx) begin
            chk({name, "_dat"}, seen[idx].dat, dat);
            chk({name, "_ovf"}, seen[idx].ovf, ovf);
        end
    endtask

    task automatic wait_rdy(input string name);
        int n = 0;
        while (!cmd_rdy && n < 100) begin
            idle(1);
            n++;
        end
        chk({name, "_rdy_timeout"}, cmd_rdy, 1);
    endtask

    initial begin
        int low;
        int lo;
        int stalls;
        bit back;
        rst_n = 1'b0;
        cmd_vld = 1'b0; cmd_op = '0; cmd_id = '0; cmd_dat = '0; clr_all = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        sweep_check("por");

        // freshly swept counter reads zero
        seen.delete();
        drive(1'b1, 6, 5, 0, 1'b0);
        idle(6);
        chk_seen("qry5_after_sweep", 0, 0, 0);

        // wrap (or clamp) on back-to-back increments
        seen.delete();
        drive(1'b1, 1, 3, 8'hFE, 1'b0);
        repeat (3) drive(1'b1, 2, 3, 0, 1'b0);
        idle(6);
        chk_seen("incr_a", 0, 8'hFE, 0);
        chk_seen("incr_b", 1, 8'hFF, 0);
        chk_seen("incr_c", 2, c_SAT ? 8'hFF : 8'h00, 1);
        chk_seen("incr_d", 3, c_SAT ? 8'hFF : 8'h01, c_SAT ? 1 : 0);

        // gapped adds, then a borrowing subtract
        seen.delete();
        drive(1'b1, 1, 2, 8'h10, 1'b0);
        idle(1);
        drive(1'b1, 4, 2, 8'h05, 1'b0);
        idle(2);
        drive(1'b1, 4, 2, 8'h05, 1'b0);
        drive(1'b1, 5, 2, 8'h20, 1'b0);
        idle(6);
        chk_seen("add_init", 0, 8'h10, 0);
        chk_seen("add_gap1", 1, 8'h15, 0);
        chk_seen("add_gap2", 2, 8'h1A, 0);
        chk_seen("sub_borrow", 3, c_SAT ? 8'h00 : 8'hFA, 1);

        // interleaved increments at full rate must never stall
        seen.delete();
        stalls = 0;
        drive(1'b1, 1, 1, 0, 1'b0);
        drive(1'b1, 1, 2, 0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (!cmd_rdy) stalls++;
            drive(1'b1, 2, (i % 2 == 0) ? 1 : 2, 0, 1'b0);
        end
        drive(1'b1, 6, 1, 0, 1'b0);
        drive(1'b1, 6, 2, 0, 1'b0);
        idle(6);
        chk("interleave_stalls", stalls, 0);
        chk_seen("interleave_qry1", 22, 10, 0);
        chk_seen("interleave_qry2", 23, 10, 0);

        // clear-all with three commands in flight
        seen.delete();
        drive(1'b1, 1, 4, 8'h33, 1'b0);
        drive(1'b1, 4, 4, 8'h01, 1'b0);
        drive(1'b1, 6, 6, 0, 1'b0);
        drive(1'b1, 2, 7, 0, 1'b1);
        cmd_vld = 1'b0;
        clr_all = 1'b0;
        low = 0;
        back = 1'b0;
        for (int i = 0; i < 100 && !back; i++) begin
            @(negedge clk);
            if (cmd_rdy) back = 1'b1;
            else low++;
        end
        chk("clr_rdy_returns", back, 1);
        lo = ((clr_last_due - clr_cyc) > 1 ? (clr_last_due - clr_cyc) : 1) + N;
        chk("clr_rdy_low_min", low >= lo - 1, 1);
        chk("clr_rdy_low_max", low <= lo + 2, 1);
        @(posedge clk);
        #1;
        chk("clr_inflight_count", seen.size(), 3);
        chk_seen("clr_inflight_a", 0, 8'h33, 0);
        chk_seen("clr_inflight_b", 1, 8'h34, 0);
        drive(1'b1, 6, 4, 0, 1'b0);
        drive(1'b1, 6, 7, 0, 1'b0);
        idle(6);
        chk_seen("clr_qry4", 3, 0, 0);
        chk_seen("clr_qry7", 4, 0, 0);

        // randomized traffic, biased to a few IDs for dense collisions
        for (int i = 0; i < 600; i++) begin
            int op = $urandom_range(0, 7);
            int id = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom_range(0, 15);
            int dat = ($urandom_range(0, 3) == 0) ? $urandom_range(240, 255) : $urandom_range(0, 255);
            drive($urandom_range(0, 3) != 0, op, id, dat, $urandom_range(0, 149) == 0);
        end

        // one-cycle reset mid-stream discards everything in flight
        wait_rdy("pre_reset");
        for (int i = 0; i < 6; i++) drive(1'b1, 2, i % 4, 0, 1'b0);
        cmd_vld = 1'b0;
        rst_n = 1'b0;
        seen.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sweep_check("midrst");
        chk("midrst_no_status", seen.size(), 0);
        for (int i = 0; i < 4; i++) drive(1'b1, 6, i, 0, 1'b0);
        idle(6);
        chk_seen("midrst_qry0", 0, 0, 0);
        chk_seen("midrst_qry3", 3, 0, 0);

        for (int i = 0; i < 200; i++)
            drive($urandom_range(0, 1) != 0, $urandom_range(0, 7), $urandom_range(0, 3),
                  $urandom_range(0, 255), 1'b0);
        idle(8);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/multi_counter_acc.md
MULTI_COUNTER_ACC -- requirements
Module: multi_counter_acc

Interface
REQ-001 SHALL have parameter CNTRS_N, default 256, number of counters.
REQ-002 SHALL have parameter CNTRS_W, default 32, counter width in bits.
REQ-003 SHALL have parameter CNTRS_ID_W, default $clog2(CNTRS_N), counter ID width.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 cmd_vld  input  1  command valid.
REQ-007 cmd_rdy  output  1  command ready; command accepted when cmd_vld & cmd_rdy.
REQ-008 cmd_id  input  CNTRS_ID_W  target counter.
REQ-009 cmd_op  input  3  opcode: 0 NOP, 1 INIT, 2 INCR, 3 DECR, 4 ADD, 5 SUB, 6 QRY, 7 reserved (treated as NOP).
REQ-010 cmd_dat  input  CNTRS_W  operand for INIT/ADD/SUB.
REQ-011 clr_all  input  1  single-cycle pulse requesting all counters be cleared.
REQ-012 status_vld_r  output  1  one pulse per accepted non-NOP command.
REQ-013 status_qry_r  output  1  qualifies status_vld_r for QRY.
REQ-014 status_id_r  output  CNTRS_ID_W  counter ID of the reported command.
REQ-015 status_dat_r  output  CNTRS_W  counter value after the command.
REQ-016 status_ovf_r  output  1  the command overflowed or underflowed.

Function
REQ-017 Counter state SHALL live in a dual-port RAM (one read port, one write port, 1-cycle read latency), not flops.
REQ-018 Accepted commands SHALL flow through a 4-stage pipeline; status outputs are valid exactly 4 cycles after acceptance, one command per cycle sustained.
REQ-019 Results SHALL equal strictly sequential execution in acceptance order; same-ID commands in any spacing, including back-to-back, use forwarding from later stages and never stale RAM data.
REQ-020 A read/write collision on the same address in one cycle SHALL take the write data.
REQ-021 INIT: new = cmd_dat. INCR/DECR: new = old +/- 1. ADD/SUB: new = old +/- cmd_dat. QRY: new = old, no write-back.
REQ-022 Arithmetic SHALL be CNTRS_W+1 bits wide; status_ovf_r = carry-out (ADD/INCR) or borrow (SUB/DECR), else 0.
REQ-023 NOP and reserved opcodes SHALL be accepted, produce no status pulse and write nothing.
REQ-024 FSM states: SWEEP, RUN, DRAIN.
REQ-025 SWEEP: write 0 to address 0..CNTRS_N-1, one per cycle, cmd_rdy=0; after the last address go to RUN.
REQ-026 RUN: cmd_rdy=1; clr_all moves to DRAIN, and a command presented in the same cycle is not accepted.
REQ-027 DRAIN: cmd_rdy=0 until the pipeline is empty, then go to SWEEP at address 0.
REQ-028 clr_all in SWEEP or DRAIN SHALL be ignored.
REQ-029 cmd_rdy SHALL be a registered output.

Reset
REQ-030 On rst_n low: FSM to SWEEP, sweep address 0, pipeline valids cleared, all outputs 0, cmd_rdy 0.
REQ-031 Reset mid-operation SHALL discard in-flight commands; no status pulse emitted for them.
REQ-032 RAM contents are not reset directly; after rst_n rises, the SWEEP pass gives all counters 0 after CNTRS_N cycles.

Configuration
REQ-033 With MULTI_COUNTER_ACC_SAT_EN defined: overflow clamps to 2^CNTRS_W-1, underflow clamps to 0, status_ovf_r still 1.
REQ-034 Without MULTI_COUNTER_ACC_SAT_EN: results wrap modulo 2^CNTRS_W, status_ovf_r still 1.

Verification (CNTRS_N=16, CNTRS_W=8)
REQ-035 Release reset -> cmd_rdy 0 for 16 cycles, then 1; QRY id 5 -> status_dat_r=0x00 4 cycles later.
REQ-036 INIT id 3 =0xFE, then INCR id 3 x3 back-to-back -> status_dat_r 0xFE, 0xFF, then 0x00 with ovf=1, then 0x01 with ovf=0; with SAT_EN: 0xFF (ovf=1), 0xFF (ovf=1).
REQ-037 INIT id 2 =0x10, then ADD id 2 0x05 with 1- and 2-cycle gaps, then SUB 0x20 -> 0x15, 0x1A, then 0xFA with ovf=1 (SAT_EN: 0x00).
REQ-038 Alternating INCR on ids 1 and 2, 20 cycles, cmd_vld always 1 -> no stalls; final QRY returns 10 on each.
REQ-039 clr_all with 3 commands in flight -> all 3 statuses emitted, cmd_rdy low through drain plus 16 sweep cycles, then QRY any id -> 0.
REQ-040 rst_n low for 1 cycle mid-stream -> no status pulse from in-flight commands, full sweep repeats.
